// File: rtl/cra_seq_if.sv
// Microsequencer control bus: per-word next-address controls in, registered CRAM address and stack status out.
interface cra_seq_if #(
    parameter int ADDR_W = 11
);
    logic              i_adv;
    logic [ADDR_W-1:0] i_j;
    logic [4:0]        i_disp;
    logic              i_call;
    logic              i_skip;
    logic [3:0]        i_disp_bits;
    logic [ADDR_W-1:0] i_dram_j;
    logic              i_diag_ld;
    logic [ADDR_W-1:0] i_diag_adr;
    logic [ADDR_W-1:0] o_cradr;
    logic [4:0]        o_stk_depth;
    logic              o_stk_err;

    modport master (
        output i_adv, i_j, i_disp, i_call, i_skip, i_disp_bits,
               i_dram_j, i_diag_ld, i_diag_adr,
        input  o_cradr, o_stk_depth, o_stk_err
    );

    modport slave (
        input  i_adv, i_j, i_disp, i_call, i_skip, i_disp_bits,
               i_dram_j, i_diag_ld, i_diag_adr,
        output o_cradr, o_stk_depth, o_stk_err
    );
endinterface

// File: rtl/cra_seq.sv
// CRAM microsequencer: registers next control-RAM address with CALL/RETURN stack.
// One edge from inputs to CRADR; ADV=0 holds all state, diagnostic load overrides ADV.
module cra_seq #(
    parameter int              ADDR_W      = 11,
    parameter int              STACK_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_ADR = '0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    cra_seq_if.slave  bus
);
    localparam int         IW        = $clog2(STACK_DEPTH);
    localparam logic [4:0] DISP_RET  = 5'o01;
    localparam logic [4:0] DISP_DRAM = 5'o02;
    localparam logic [4:0] DISP_MULT = 5'o03;
    localparam logic [4:0] MAX_DEPTH = 5'(STACK_DEPTH);

    logic [ADDR_W-1:0] r_cradr;
    logic [4:0]        r_depth;
    logic              r_err;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_empty;
    logic              w_full;
    logic              w_is_ret;
    logic              w_step;
    logic [IW-1:0]     w_wr_idx;
    logic [IW-1:0]     w_top_idx;
    logic [ADDR_W-1:0] w_pop;
    logic [ADDR_W-1:0] w_bits;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_next;

    assign w_empty   = (r_depth == 5'd0);
    assign w_full    = (r_depth == MAX_DEPTH);
    assign w_is_ret  = (bus.i_disp == DISP_RET);
    assign w_step    = bus.i_adv && !bus.i_diag_ld;
    assign w_wr_idx  = r_depth[IW-1:0];
    assign w_top_idx = w_wr_idx - IW'(1);
    // An empty stack pops as zero so a stray RETURN lands on the dispatch bits alone.
    assign w_pop     = w_empty ? '0 : r_stack[w_top_idx];
    assign w_bits    = {{(ADDR_W-4){1'b0}}, bus.i_disp_bits};

    always_comb begin
        w_base = bus.i_j;
        case (bus.i_disp)
            DISP_RET:  w_base = w_pop | w_bits;
            DISP_DRAM: w_base = bus.i_dram_j;
            DISP_MULT: w_base = bus.i_j | w_bits;
            default:   w_base = bus.i_j;
        endcase
    end

    assign w_next = w_base | {{(ADDR_W-1){1'b0}}, bus.i_skip};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cradr <= RESET_ADR;
            r_depth <= 5'd0;
            r_err   <= 1'b0;
        end else if (bus.i_diag_ld) begin
            r_cradr <= bus.i_diag_adr;
        end else if (bus.i_adv) begin
            r_cradr <= w_next;
            if (bus.i_call && !w_is_ret) begin
                if (w_full) r_err   <= 1'b1;
                else        r_depth <= r_depth + 5'd1;
            end else if (w_is_ret && !bus.i_call) begin
                if (w_empty) r_err   <= 1'b1;
                else         r_depth <= r_depth - 5'd1;
            end
        end
    end

    // CALL+RETURN reuses the slot just popped; depth is unchanged so nothing lands at depth 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_step && bus.i_call) begin
            if (w_is_ret) begin
                if (!w_empty) r_stack[w_top_idx] <= r_cradr;
            end else if (!w_full) begin
                r_stack[w_wr_idx] <= r_cradr;
            end
        end
    end

    assign bus.o_cradr     = r_cradr;
    assign bus.o_stk_depth = r_depth;
    assign bus.o_stk_err   = r_err;
endmodule

// File: tb/tb_cra_seq.sv
// Bench for cra_seq: directed test-plan steps followed by random microcycles against a queue-based model.
module tb_cra_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cra_seq_if #(.ADDR_W(11)) bus ();

    cra_seq #(.ADDR_W(11), .STACK_DEPTH(16), .RESET_ADR(11'o0000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;

    logic [10:0] m_cradr;
    logic        m_err;
    logic [10:0] m_stk [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_adv       = 1'b0;
        bus.i_j         = '0;
        bus.i_disp      = '0;
        bus.i_call      = 1'b0;
        bus.i_skip      = 1'b0;
        bus.i_disp_bits = '0;
        bus.i_dram_j    = '0;
        bus.i_diag_ld   = 1'b0;
        bus.i_diag_adr  = '0;
    endtask

    task automatic model_edge();
        logic [10:0] top, base;
        logic        ret;
        if (rst) begin
            m_cradr = 11'o0000;
            m_err   = 1'b0;
            m_stk.delete();
        end else if (bus.i_diag_ld) begin
            m_cradr = bus.i_diag_adr;
        end else if (bus.i_adv) begin
            ret = (bus.i_disp == 5'd1);
            top = (m_stk.size() > 0) ? m_stk[$] : 11'd0;
            case (bus.i_disp)
                5'd1:    base = top | 11'(bus.i_disp_bits);
                5'd2:    base = bus.i_dram_j;
                5'd3:    base = bus.i_j | 11'(bus.i_disp_bits);
                default: base = bus.i_j;
            endcase
            if (bus.i_call && ret) begin
                if (m_stk.size() > 0) begin
                    void'(m_stk.pop_back());
                    m_stk.push_back(m_cradr);
                end
            end else if (bus.i_call) begin
                if (m_stk.size() < 16) m_stk.push_back(m_cradr);
                else                   m_err = 1'b1;
            end else if (ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else                  m_err = 1'b1;
            end
            m_cradr = base | 11'(bus.i_skip);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".cradr"}, 32'(bus.o_cradr), 32'(m_cradr));
        chk({tag, ".depth"}, 32'(bus.o_stk_depth), 32'(m_stk.size()));
        chk({tag, ".err"},   32'(bus.o_stk_err), 32'(m_err));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step("reset");
        chk("reset_cradr_const", 32'(bus.o_cradr), 32'h0);
        rst = 1'b0;

        bus.i_adv = 1'b1; bus.i_j = 11'o0100;
        step("jump");
        chk("jump_const", 32'(bus.o_cradr), 32'o0100);
        bus.i_j = 11'o0200; bus.i_skip = 1'b1;
        step("skip");
        chk("skip_const", 32'(bus.o_cradr), 32'o0201);
        bus.i_skip = 1'b0; bus.i_disp = 5'd3; bus.i_j = 11'o0300; bus.i_disp_bits = 4'b1010;
        step("multi");
        chk("multi_const", 32'(bus.o_cradr), 32'o0312);
        idle();
        for (int i = 0; i < 3; i++) step("hold");
        chk("hold_const", 32'(bus.o_cradr), 32'o0312);

        bus.i_adv = 1'b1; bus.i_j = 11'o0500;
        step("goto500");
        bus.i_call = 1'b1; bus.i_j = 11'o1000;
        step("call");
        chk("call_depth_const", 32'(bus.o_stk_depth), 32'd1);
        bus.i_call = 1'b0; bus.i_disp = 5'd1; bus.i_disp_bits = 4'd2;
        step("return");
        chk("return_const", 32'(bus.o_cradr), 32'o0502);

        bus.i_disp = 5'd0; bus.i_disp_bits = 4'd0; bus.i_call = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.i_j = 11'(i * 8 + 8);
            step("callchain");
        end
        chk("sat_depth_const", 32'(bus.o_stk_depth), 32'd16);
        chk("sat_err_const", 32'(bus.o_stk_err), 32'd1);
        bus.i_call = 1'b0; bus.i_disp = 5'd1;
        for (int i = 0; i < 16; i++) step("retchain");
        step("underflow");
        chk("underflow_const", 32'(bus.o_cradr), 32'h0);

        bus.i_j = 11'o0040; bus.i_disp = 5'd0; bus.i_call = 1'b1;
        step("precall");
        bus.i_diag_ld = 1'b1; bus.i_diag_adr = 11'o1777;
        step("diag");
        chk("diag_const", 32'(bus.o_cradr), 32'o1777);
        rst = 1'b1;
        step("rst_diag");
        chk("rst_diag_depth_const", 32'(bus.o_stk_depth), 32'd0);
        rst = 1'b0;
        idle();

        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            bus.i_adv       = ($urandom_range(0, 5) != 0);
            bus.i_j         = 11'($urandom);
            bus.i_disp      = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            bus.i_call      = ($urandom_range(0, 2) == 0);
            bus.i_skip      = 1'($urandom);
            bus.i_disp_bits = 4'($urandom);
            bus.i_dram_j    = 11'($urandom);
            bus.i_diag_ld   = ($urandom_range(0, 19) == 0);
            bus.i_diag_adr  = 11'($urandom);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cra_seq.md
Name: cra_seq

Overview:
- Microsequencer upstream of the CRAM store: computes and registers the 11-bit control RAM address CRADR each microcycle.
- Next-address sources: the current word's J field, DRAM dispatch target, multiway dispatch bits, skip condition, and a microcode subroutine stack (CALL/RETURN).
- CRADR drives the CRAM read address directly. Diagnostic load forces an arbitrary address.

Parameters:
ADDR_W, 11, CRAM address width (2K words)
STACK_DEPTH, 16, subroutine return-stack entries
RESET_ADR, 0, CRADR value after reset

Ports:
CLK  in  1  microcode clock; all state changes on rising edge
RESET  in  1  synchronous, active-high
ADV  in  1  advance enable; 1 = load next address this edge, 0 = hold all state
J  in  ADDR_W  J field of current microword
DISP  in  5  dispatch select from current microword
CALL  in  1  CALL bit of current microword
SKIP  in  1  selected skip condition (already evaluated from COND)
DISP_BITS  in  4  low-order multiway/return dispatch bits
DRAM_J  in  ADDR_W  DRAM dispatch target
DIAG_LD  in  1  diagnostic force-address strobe
DIAG_ADR  in  ADDR_W  diagnostic address
CRADR  out  ADDR_W  registered CRAM address
STK_DEPTH  out  5  current stack occupancy, 0..STACK_DEPTH
STK_ERR  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset values: CRADR=RESET_ADR, STK_DEPTH=0, STK_ERR=0, stack contents don't-care.
- Priority per edge: RESET > DIAG_LD > ADV.
- DIAG_LD=1: CRADR<=DIAG_ADR. Stack and STK_ERR unchanged. ADV, CALL and DISP are ignored.
- ADV=0, no DIAG_LD: every register holds.
- ADV=1, base address B selected by DISP:
  - 5'o00: B=J
  - 5'o01 (RETURN): B = popped top | {0, DISP_BITS}
  - 5'o02 (DRAM): B=DRAM_J
  - 5'o03 (MULTI): B = J | {0, DISP_BITS}
  - all other codes: B=J
- Next CRADR = B | {0, SKIP}. Skip ORs into the LSB in every ADV mode.
- CALL=1 with ADV=1: pushes the current CRADR (the address of the executing word) and increments depth.
- CALL and RETURN together: pop value forms B, then current CRADR is written into the vacated slot. Depth unchanged. No error, even at depth 0, since the push refills.
- RETURN at depth 0 without CALL: popped value = 0, so B = {0, DISP_BITS}. Depth stays 0. STK_ERR<=1.
- CALL at depth STACK_DEPTH without RETURN: push discarded, depth stays STACK_DEPTH, STK_ERR<=1. Next address is still computed normally.
- STK_ERR clears only on RESET.
- Latency: one CLK edge from inputs to CRADR. No combinational path from inputs to any output.
- Stack is LIFO, implemented as a register array plus depth pointer. No wrap-around.

Test Plan:
- Reset then ADV=1, DISP=0, J=11'o0100, SKIP=0 -> CRADR=0 after reset, 11'o0100 after the edge; STK_DEPTH=0.
- J=11'o0200, SKIP=1 -> CRADR=11'o0201. Then DISP=3, J=11'o0300, DISP_BITS=4'b1010 -> CRADR=11'o0312. Then ADV=0 for 3 cycles -> CRADR holds 11'o0312.
- CRADR=11'o0500, CALL=1, J=11'o1000 -> CRADR=11'o1000, depth 1. Then DISP=1, DISP_BITS=2 -> CRADR=11'o0502, depth 0, STK_ERR=0.
- 17 consecutive CALLs -> depth saturates at 16, STK_ERR=1. Then 16 RETURNs with DISP_BITS=0 -> addresses come back in reverse push order. A 17th RETURN -> CRADR=0, STK_ERR remains 1.
- DIAG_LD=1 with DIAG_ADR=11'o1777 while ADV=1, CALL=1 -> CRADR=11'o1777, depth unchanged. RESET asserted together with DIAG_LD -> CRADR=RESET_ADR, depth 0, STK_ERR=0.
